// File: rtl/ext_unit_pipe_pkg.sv
// Shared types and mode encodings for the
// pipelined immediate-extension unit.
package ext_unit_pipe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ZE     = 2'b00;
  localparam mode_t MODE_SE     = 2'b01;
  localparam mode_t MODE_SE_SH2 = 2'b10;
  localparam mode_t MODE_UPPER  = 2'b11;

endpackage

// File: rtl/ext_unit_pipe_if.sv
// Decode-side and execute-side handshake bundle
// of the immediate-extension unit.
interface ext_unit_pipe_if
  import ext_unit_pipe_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  mode_t            out_mode;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid,
    output in_imm,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_mode,
    input  done_cnt
  );

  modport slave (
    input  in_valid,
    input  in_imm,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_mode,
    output done_cnt
  );

endinterface

// File: rtl/ext_unit_pipe_ext_comb.sv
// Combinational immediate extender:
// ZE, SE, SE<<2 and upper placement.
module ext_comb
  import ext_unit_pipe_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  mode_t            mode,
  output logic [OUT_W-1:0] ext
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] se;

  assign se = {{PAD{imm[IN_W-1]}}, imm};

  always_comb begin
    ext = '0;
    unique case (1'b1)
      (mode == MODE_ZE):     ext = {{PAD{1'b0}}, imm};
      (mode == MODE_SE):     ext = se;
      (mode == MODE_SE_SH2): ext = {se[OUT_W-3:0], 2'b00};
      (mode == MODE_UPPER):  ext = {imm, {PAD{1'b0}}};
      default:               ext = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Immediate-extension stage between decode and
// execute, with a DEPTH-entry circular buffer.
module ext_unit_pipe
  import ext_unit_pipe_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  ext_unit_pipe_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);

  logic [OUT_W-1:0] data_q [DEPTH];
  mode_t            mode_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] done_q;
  logic [OUT_W-1:0] ext_data;
  logic             push;
  logic             pop;
  logic             nonempty;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .ext  (ext_data)
  );

  assign nonempty     = (count != '0);
  assign bus.in_ready = (count < FULL);
  assign bus.out_valid = nonempty;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = nonempty & bus.out_ready;

  // Empty buffer reads as zero; stale entries stay hidden.
  assign bus.out_data = nonempty ? data_q[rd_ptr] : '0;
  assign bus.out_mode = nonempty ? mode_q[rd_ptr] : MODE_ZE;
  assign bus.done_cnt = done_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done_q <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
        done_q <= done_q + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= ext_data;
      mode_q[wr_ptr] <= bus.in_mode;
    end
  end

endmodule
